// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the time-shared read mux arbiter.
package mux_arb_pkg;
  localparam int MUX_ARB_NREQ     = 4;
  localparam int MUX_ARB_ADDR_W   = 5;
  localparam int MUX_ARB_DATA_W   = 64;
  localparam int MUX_ARB_MAX_LOCK = 4;

  typedef logic [MUX_ARB_NREQ-1:0]   req_vec_t;
  typedef logic [MUX_ARB_ADDR_W-1:0] sel_t;
endpackage

// File: rtl/mux_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);
  int j;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = PW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_read_arbiter.sv
// Round-robin owner of a shared read mux: registered grant/select, then registered data.
// Optional grant locking (up to MUX_ARB_MAX_LOCK in a row) with MUX_READ_ARBITER_LOCK_EN.
module mux_read_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ   = MUX_ARB_NREQ,
  parameter int ADDR_W = MUX_ARB_ADDR_W,
  parameter int DATA_W = MUX_ARB_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr,
`ifdef MUX_READ_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]        lock,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [ADDR_W-1:0]      sel,
  input  logic [DATA_W-1:0]      mux_y,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic                   busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   gnt_q, gnt_d, rvalid_q;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q;

  logic [NREQ-1:0]   pick_req, pick_oh;
  logic [PW-1:0]     pick_idx;
  logic              pick_vld;

`ifdef MUX_READ_ARBITER_LOCK_EN
  logic [2:0]    lock_cnt_q, lock_cnt_d;
  logic          hold, relock;
  logic [PW-1:0] hold_idx;
`endif

  // Requests seen by the picker; a capped lock holder sits out one round.
  always_comb begin
    pick_req = req;
`ifdef MUX_READ_ARBITER_LOCK_EN
    hold     = |(gnt_q & req & lock);
    relock   = hold && (lock_cnt_q < 3'(MUX_ARB_MAX_LOCK));
    hold_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) hold_idx = PW'(i);
    if (hold && !relock) pick_req = req & ~gnt_q;
`endif
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i    (pick_req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  always_comb begin
    gnt_d = '0;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (pick_vld) begin
      gnt_d = pick_oh;
      sel_d = addr[pick_idx*ADDR_W +: ADDR_W];
      ptr_d = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
    end
`ifdef MUX_READ_ARBITER_LOCK_EN
    lock_cnt_d = pick_vld ? 3'd1 : 3'd0;
    if (relock) begin
      gnt_d      = gnt_q;
      sel_d      = addr[hold_idx*ADDR_W +: ADDR_W];
      ptr_d      = ptr_q;
      lock_cnt_d = lock_cnt_q + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      rvalid_q <= gnt_q;
      if (|gnt_q) rdata_q <= mux_y;
    end
  end

`ifdef MUX_READ_ARBITER_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
  end
`endif

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (|gnt_q) | (|rvalid_q);
endmodule

// File: tb/tb_mux_read_arbiter.sv
// Scoreboard bench for mux_read_arbiter; lock scenarios build with MUX_READ_ARBITER_LOCK_EN.
module tb_mux_read_arbiter;
  import mux_arb_pkg::*;

  logic          clk, reset;
  req_vec_t      req, gnt, rvalid;
  logic [19:0]   addr;
  sel_t          sel;
  logic [63:0]   mux_y, rdata;
  logic          busy;
`ifdef MUX_READ_ARBITER_LOCK_EN
  req_vec_t      lock_v;
`endif

  typedef struct packed {
    logic [3:0]  gnt;
    logic [4:0]  sel;
    logic [3:0]  rv;
    logic [63:0] rd;
    logic        busy;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  logic [3:0]  m_gnt, m_rv;
  logic [4:0]  m_sel;
  logic [63:0] m_rd;
  int          m_ptr, m_cnt;
  int          n_chk, n_pass;

  mux_read_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
`ifdef MUX_READ_ARBITER_LOCK_EN
    .lock   (lock_v),
`endif
    .gnt    (gnt),
    .sel    (sel),
    .mux_y  (mux_y),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  function automatic logic [63:0] mux_f(input logic [4:0] s);
    return {32'h0, 32'hDEAD_0000 | {27'h0, s}};
  endfunction

  assign mux_y = mux_f(sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input logic [3:0] r, input logic rs, input logic [19:0] ad);
    exp_t e;
    logic [3:0]  n_gnt, n_rv, cand;
    logic [4:0]  n_sel;
    logic [63:0] n_rd;
    int          n_ptr, n_cnt, w;
    logic        relocked;
    req = r; reset = rs; addr = ad;
    if (rs) begin
      n_gnt = '0; n_sel = '0; n_rv = '0; n_rd = '0; n_ptr = 0; n_cnt = 0;
    end else begin
      n_rv  = m_gnt;
      n_rd  = (m_gnt != 0) ? mux_f(m_sel) : m_rd;
      n_gnt = '0; n_sel = m_sel; n_ptr = m_ptr; n_cnt = 0;
      cand = r; relocked = 1'b0;
`ifdef MUX_READ_ARBITER_LOCK_EN
      if ((m_gnt & r & lock_v) != 0) begin
        if (m_cnt < 4) begin
          relocked = 1'b1;
          n_gnt = m_gnt;
          n_cnt = m_cnt + 1;
          for (int i = 0; i < 4; i++) if (m_gnt[i]) n_sel = ad[i*5 +: 5];
        end else cand = r & ~m_gnt;
      end
`endif
      if (!relocked) begin
        w = -1;
        for (int off = 0; off < 4; off++)
          if (w < 0 && cand[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
        if (w >= 0) begin
          n_gnt = 4'b0001 << w;
          n_sel = ad[w*5 +: 5];
          n_ptr = (w + 1) % 4;
          n_cnt = 1;
        end
      end
    end
    m_gnt = n_gnt; m_sel = n_sel; m_rv = n_rv; m_rd = n_rd; m_ptr = n_ptr; m_cnt = n_cnt;
    e.gnt = n_gnt; e.sel = n_sel; e.rv = n_rv; e.rd = n_rd; e.busy = (n_gnt != 0) || (n_rv != 0);
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    check("gnt",    64'(gnt),    64'(e.gnt));
    check("sel",    64'(sel),    64'(e.sel));
    check("rvalid", 64'(rvalid), 64'(e.rv));
    check("rdata",  rdata,       e.rd);
    check("busy",   64'(busy),   64'(e.busy));
  endtask

  initial begin
    logic [19:0] a17;
    n_chk = 0; n_pass = 0;
    m_gnt = '0; m_rv = '0; m_sel = '0; m_rd = '0; m_ptr = 0; m_cnt = 0;
    reset = 1'b1; req = '0; addr = '0;
`ifdef MUX_READ_ARBITER_LOCK_EN
    lock_v = '0;
`endif
    // reset dominance with all requesting
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, 20'hABCDE);
      check("rst_gnt", 64'(gnt), 64'h0);
    end

    // single read: requester 2, address 17
    a17 = 20'h0;
    a17[14:10] = 5'd17;
    step(4'b0100, 1'b0, a17);
    check("single_gnt", 64'(gnt), 64'h4);
    check("single_sel", 64'(sel), 64'd17);
    step(4'b0000, 1'b0, a17);
    check("single_rvalid", 64'(rvalid), 64'h4);
    check("single_rdata", rdata, 64'hDEAD_0011);

    // round-robin from reset
    step(4'b0000, 1'b1, 20'h0);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b0, 20'h12345 + 20'(k));
      check("rr_seq", 64'(gnt), 64'(4'b0001 << (k % 4)));
    end

    // skip and wrap: ptr=3 after grant to 2
    step(4'b0000, 1'b1, 20'h0);
    step(4'b0100, 1'b0, 20'h31CE7);
    step(4'b0101, 1'b0, 20'h31CE7);
    check("wrap_gnt0", 64'(gnt), 64'h1);
    step(4'b0101, 1'b0, 20'h31CE7);
    check("wrap_gnt2", 64'(gnt), 64'h4);

    // reset with a grant in flight
    step(4'b0000, 1'b1, 20'h0);
    step(4'b0010, 1'b0, 20'h0F0F0);
    check("mid_gnt", 64'(gnt), 64'h2);
    step(4'b0010, 1'b1, 20'h0F0F0);
    check("mid_rvalid", 64'(rvalid), 64'h0);
    step(4'b0011, 1'b0, 20'h0F0F0);
    check("mid_first", 64'(gnt), 64'h1);
    step(4'b0000, 1'b0, 20'h0F0F0);

`ifdef MUX_READ_ARBITER_LOCK_EN
    step(4'b0000, 1'b1, 20'h0);
    lock_v = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step(4'b0011, 1'b0, 20'h54321);
      check("lock_seq", 64'(gnt), (k == 4) ? 64'h2 : 64'h1);
    end
    lock_v = 4'b0000;
`endif

    // random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
`ifdef MUX_READ_ARBITER_LOCK_EN
      lock_v = 4'($urandom);
`endif
      step(4'($urandom), ($urandom_range(0, 19) == 0), 20'($urandom));
      check("gnt_onehot", 64'($onehot0(gnt)), 64'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
